// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state type and helpers for the EX-stage ALU with
// iterative multiply/divide.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_RSVD  = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_iter_md.sv
// Iterative magnitude multiply (radix-2 shift-add) and restoring divide.
// One bit per cycle for Width cycles after start_i; operands are unsigned magnitudes.
module alu_iter_md #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] lo_o,
  output logic [Width-1:0] hi_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [Width:0]   mul_sum, div_shift;
  logic             div_ge;

  always_comb begin
    busy_d    = busy_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[Width-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    if (start_i) begin
      busy_d = 1'b1;
      div_d  = div_i;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = a_i;
      b_d    = b_i;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LastCnt) busy_d = 1'b0;
      if (div_q) begin
        // hi holds the partial remainder, lo shifts dividend out and quotient in
        hi_d = div_ge ? div_shift[Width-1:0] - b_q : div_shift[Width-1:0];
        lo_d = {lo_q[Width-2:0], div_ge};
      end else begin
        hi_d = mul_sum[Width:1];
        lo_d = {mul_sum[0], lo_q[Width-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
    end
  end

  assign done_o = busy_q & (cnt_q == LastCnt);
  assign lo_o   = lo_q;
  assign hi_o   = hi_q;

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU: single-cycle logic/arith/shift ops plus iterative mul/div,
// all results registered behind a valid/ready handshake.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            ALUop,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [DATA_WIDTH-1:0] ResultHi,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  localparam int unsigned W = DATA_WIDTH;

  state_e         state_q, state_d;
  logic           signed_q, signed_d, div_q, div_d, b_sign_q, b_sign_d, b_zero_q, b_zero_d;
  logic [W-1:0]   a_q, a_d, res_q, res_d, res_hi_q, res_hi_d;
  logic           ovf_q, ovf_d, cy_q, cy_d, zero_q, zero_d;
  logic           accept, md_start, md_done;
  logic [W-1:0]   md_lo, md_hi, a_mag, b_mag;

  logic           sub_op, ovf_raw, borrow;
  logic [W-1:0]   b_eff, simp_res;
  logic [W:0]     sum;
  logic           simp_ovf, simp_cy;
  logic [SHAMT_W-1:0] shamt;

  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   fix_lo, fix_hi;

  assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = state_q == StDone;

  // Simple ops share one adder; everything except ADD subtracts.
  always_comb begin
    sub_op   = ALUop != OP_ADD;
    b_eff    = sub_op ? ~B : B;
    sum      = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, sub_op};
    ovf_raw  = (A[W-1] == b_eff[W-1]) && (sum[W-1] != A[W-1]);
    borrow   = ~sum[W];
    shamt    = B[SHAMT_W-1:0];
    simp_res = '0;
    simp_ovf = 1'b0;
    simp_cy  = 1'b0;
    case (ALUop)
      OP_AND:  simp_res = A & B;
      OP_OR:   simp_res = A | B;
      OP_XOR:  simp_res = A ^ B;
      OP_NOR:  simp_res = ~(A | B);
      OP_ADD:  begin simp_res = sum[W-1:0]; simp_ovf = ovf_raw; simp_cy = sum[W]; end
      OP_SUB:  begin simp_res = sum[W-1:0]; simp_ovf = ovf_raw; simp_cy = borrow; end
      OP_SLTU: simp_res = {{(W-1){1'b0}}, borrow};
      OP_SLT:  simp_res = {{(W-1){1'b0}}, sum[W-1] ^ ovf_raw};
      OP_SLL:  simp_res = A << shamt;
      OP_SRL:  simp_res = A >> shamt;
      OP_SRA:  simp_res = $signed(A) >>> shamt;
      default: simp_res = '0;
    endcase
  end

  assign a_mag = (~ALUop[0] & A[W-1]) ? -A : A;
  assign b_mag = (~ALUop[0] & B[W-1]) ? -B : B;

  alu_iter_md #(
    .Width(W)
  ) u_iter_md (
    .clk_i  (clk),
    .rst_ni (resetn),
    .start_i(md_start),
    .div_i  (ALUop[1]),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .done_o (md_done),
    .lo_o   (md_lo),
    .hi_o   (md_hi)
  );

  // Sign fix-up of magnitude results; MIN/-1 falls out naturally as MIN rem 0.
  always_comb begin
    prod     = {md_hi, md_lo};
    prod_fix = (signed_q & (a_q[W-1] ^ b_sign_q)) ? -prod : prod;
    if (!div_q) begin
      fix_lo = prod_fix[W-1:0];
      fix_hi = prod_fix[2*W-1:W];
    end else if (b_zero_q) begin
      fix_lo = '1;
      fix_hi = a_q;
    end else begin
      fix_lo = (signed_q & (a_q[W-1] ^ b_sign_q)) ? -md_lo : md_lo;
      fix_hi = (signed_q & a_q[W-1]) ? -md_hi : md_hi;
    end
  end

  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    div_d    = div_q;
    b_sign_d = b_sign_q;
    b_zero_d = b_zero_q;
    a_d      = a_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    ovf_d    = ovf_q;
    cy_d     = cy_q;
    zero_d   = zero_q;
    md_start = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (is_multicycle(ALUop)) begin
            md_start = 1'b1;
            state_d  = ALUop[1] ? StDiv : StMul;
            signed_d = ~ALUop[0];
            div_d    = ALUop[1];
            a_d      = A;
            b_sign_d = B[W-1];
            b_zero_d = B == '0;
          end else begin
            state_d  = StDone;
            res_d    = simp_res;
            res_hi_d = '0;
            ovf_d    = simp_ovf;
            cy_d     = simp_cy;
            zero_d   = simp_res == '0;
          end
        end else if (state_q == StDone && out_ready) begin
          state_d = StIdle;
        end
      end
      StMul, StDiv: if (md_done) state_d = StFix;
      StFix: begin
        state_d  = StDone;
        res_d    = fix_lo;
        res_hi_d = fix_hi;
        ovf_d    = 1'b0;
        cy_d     = 1'b0;
        zero_d   = fix_lo == '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      signed_q <= 1'b0;
      div_q    <= 1'b0;
      b_sign_q <= 1'b0;
      b_zero_q <= 1'b0;
      a_q      <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      ovf_q    <= 1'b0;
      cy_q     <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      div_q    <= div_d;
      b_sign_q <= b_sign_d;
      b_zero_q <= b_zero_d;
      a_q      <= a_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      ovf_q    <= ovf_d;
      cy_q     <= cy_d;
      zero_q   <= zero_d;
    end
  end

  assign Result   = res_q;
  assign ResultHi = res_hi_q;
  assign Overflow = ovf_q;
  assign CarryOut = cy_q;
  assign Zero     = zero_q;

endmodule
